// File: rtl/nic_arb_pkg.sv
// -----------------------------------------------------------------------------
// nic_arb_pkg
//   Shared definitions for the NIC slot power-arbitration blocks.
//   - Arbiter FSM state encodings. Legacy tools decode these raw values
//     from the debug port, so they are plain constants, not an enum.
//   - Default width of the shared 1ms tick counter.
// -----------------------------------------------------------------------------
package nic_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;   // looking for a pending slot
   localparam logic [1:0] ST_WAIT = 2'd1;   // grant window open for one slot
   localparam logic [1:0] ST_GAP  = 2'd2;   // stagger gap after a grant closes

   localparam int ARB_CNT_W = 16;           // default ms counter width

endpackage : nic_arb_pkg

// File: rtl/nic_rr_picker.sv
// -----------------------------------------------------------------------------
// nic_rr_picker
//   Combinational round-robin first-one finder. Searches the pending vector
//   starting at slot (iPtr + 1) and wraps around, so the slot at iPtr itself
//   is considered last.
//
// Ports
//   iPending  in   NUM_SLOTS  slots currently eligible for a grant
//   iPtr      in   IDX_W      index of the most recently served slot
//   oFound    out  1          at least one slot is pending
//   oIdx      out  IDX_W      winning slot index (0 when oFound is low)
// -----------------------------------------------------------------------------
module nic_rr_picker #(
   parameter int NUM_SLOTS = 4,
   parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] iPending,
   input  logic [IDX_W-1:0]     iPtr,
   output logic                 oFound,
   output logic [IDX_W-1:0]     oIdx
);

   // Distance of the current best candidate from iPtr+1 (mod NUM_SLOTS).
   int bestDist;

   // Every slot gets a distance (i - iPtr - 1) mod NUM_SLOTS; the pending
   // slot with the smallest distance wins. This avoids variable-index
   // rotation and stays correct for non power-of-two slot counts.
   always_comb begin
      oFound   = 1'b0;
      oIdx     = '0;
      bestDist = NUM_SLOTS;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (iPending[i] &&
             (((i + NUM_SLOTS - 1 - int'(iPtr)) % NUM_SLOTS) < bestDist)) begin
            bestDist = (i + NUM_SLOTS - 1 - int'(iPtr)) % NUM_SLOTS;
            oFound   = 1'b1;
            oIdx     = IDX_W'(i);
         end
      end
   end

endmodule : nic_rr_picker

// File: rtl/nic_pwr_stagger_arb.sv
// -----------------------------------------------------------------------------
// nic_pwr_stagger_arb
//   Round-robin power-up scheduler for OCP3 NIC slot sequencers. Main-power
//   enable is granted to one slot at a time; the grant window closes when the
//   slot reports power-on done, drops its request, or times out. A stagger gap
//   of GAP_MS ticks follows each grant to limit P12V inrush.
//
// Build option
//   NIC_ARB_TIMEOUT_EN  defined  : WAIT times out after TIMEOUT_MS ticks and
//                                  latches a per-slot fault.
//                       undefined: WAIT exits only on done or request drop;
//                                  oSLOT_FLT is tied to 0.
//
// Ports
//   iClk              in   1          module clock
//   iRst              in   1          synchronous, active-high reset
//   iTick_1ms         in   1          one-cycle pulse every 1ms
//   iPWR_REQ          in   NUM_SLOTS  per-slot power request (level)
//   iPWR_DONE         in   NUM_SLOTS  per-slot sequencer in main-power mode
//   oPWR_EN           out  NUM_SLOTS  per-slot main-power enable
//   oGRANT_VLD        out  1          a slot is in its grant window
//   oGRANT_IDX        out  IDX_W      index of the granted slot
//   oSLOT_FLT         out  NUM_SLOTS  per-slot latched timeout fault
//   oDBG_ARB_FSM_curr out  2          current FSM state encoding
//
// Handshake: a slot is served when it holds iPWR_REQ while not enabled and
// not faulted; the grant is acknowledged by iPWR_DONE (level) or withdrawn by
// dropping iPWR_REQ, and dropping iPWR_REQ always removes the slot's enable.
// -----------------------------------------------------------------------------
module nic_pwr_stagger_arb
   import nic_arb_pkg::*;
#(
   parameter int NUM_SLOTS  = 4,
   parameter int GAP_MS     = 50,
   parameter int TIMEOUT_MS = 1200,
   parameter int CNT_W      = ARB_CNT_W,
   localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iTick_1ms,
   input  logic [NUM_SLOTS-1:0] iPWR_REQ,
   input  logic [NUM_SLOTS-1:0] iPWR_DONE,
   output logic [NUM_SLOTS-1:0] oPWR_EN,
   output logic                 oGRANT_VLD,
   output logic [IDX_W-1:0]     oGRANT_IDX,
   output logic [NUM_SLOTS-1:0] oSLOT_FLT,
   output logic [1:0]           oDBG_ARB_FSM_curr
);

`ifdef NIC_ARB_TIMEOUT_EN
   localparam logic TIMEOUT_EN = 1'b1;
`else
   localparam logic TIMEOUT_EN = 1'b0;
`endif

   logic [1:0]           stateCurr;
   logic [NUM_SLOTS-1:0] pwrEn;
   logic                 grantVld;
   logic [IDX_W-1:0]     grantIdx;
   logic [NUM_SLOTS-1:0] slotFlt;
   logic [CNT_W-1:0]     msCnt;
   logic [IDX_W-1:0]     rrPtr;

   logic [NUM_SLOTS-1:0] pending;
   logic                 pickFound;
   logic [IDX_W-1:0]     pickIdx;
   logic [CNT_W-1:0]     msCntInc;
   logic                 reqGranted;
   logic                 doneGranted;
   logic                 timeoutHit;
   logic                 gapDone;

   // A faulted slot stays out of arbitration until its request drops.
   assign pending = iPWR_REQ & ~pwrEn & ~slotFlt;

   nic_rr_picker #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) uPicker (
      .iPending (pending),
      .iPtr     (rrPtr),
      .oFound   (pickFound),
      .oIdx     (pickIdx)
   );

   // Saturating tick counter: holds at all-ones rather than wrapping, so a
   // long wait can never alias back to a small count.
   assign msCntInc = (iTick_1ms && (msCnt != '1)) ? msCnt + 1'b1 : msCnt;

   assign reqGranted  = iPWR_REQ[grantIdx];
   assign doneGranted = iPWR_DONE[grantIdx];
   assign timeoutHit  = TIMEOUT_EN && (msCnt == CNT_W'(TIMEOUT_MS));
   assign gapDone     = (msCnt == CNT_W'(GAP_MS));

   always_ff @(posedge iClk) begin
      if (iRst) begin
         stateCurr <= ST_IDLE;
         pwrEn     <= '0;
         grantVld  <= 1'b0;
         grantIdx  <= '0;
         slotFlt   <= '0;
         msCnt     <= '0;
         rrPtr     <= IDX_W'(NUM_SLOTS - 1);
      end else begin
         // Request drop releases a slot's enable and clears its fault in any
         // state. For the granted slot in WAIT the FSM branch below performs
         // the same release and additionally closes the grant window.
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!iPWR_REQ[i]) begin
               pwrEn[i]   <= 1'b0;
               slotFlt[i] <= 1'b0;
            end
         end

         case (stateCurr)
            ST_IDLE: begin
               if (pickFound) begin
                  pwrEn[pickIdx] <= 1'b1;
                  grantIdx       <= pickIdx;
                  grantVld       <= 1'b1;
                  msCnt          <= '0;
                  stateCurr      <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               msCnt <= msCntInc;
               // Drop beats done beats timeout when they coincide.
               if (!reqGranted || doneGranted || timeoutHit) begin
                  if (!reqGranted) begin
                     pwrEn[grantIdx] <= 1'b0;
                  end else if (!doneGranted) begin
                     slotFlt[grantIdx] <= 1'b1;
                     pwrEn[grantIdx]   <= 1'b0;
                  end
                  rrPtr     <= grantIdx;
                  grantVld  <= 1'b0;
                  msCnt     <= '0;
                  stateCurr <= ST_GAP;
               end
            end

            ST_GAP: begin
               msCnt <= msCntInc;
               if (gapDone) begin
                  msCnt     <= '0;
                  stateCurr <= ST_IDLE;
               end
            end

            default: begin
               grantVld  <= 1'b0;
               stateCurr <= ST_IDLE;
            end
         endcase
      end
   end

   assign oPWR_EN           = pwrEn;
   assign oGRANT_VLD        = grantVld;
   assign oGRANT_IDX        = grantIdx;
   assign oSLOT_FLT         = TIMEOUT_EN ? slotFlt : '0;
   assign oDBG_ARB_FSM_curr = stateCurr;

endmodule : nic_pwr_stagger_arb

// File: tb/tb_nic_pwr_stagger_arb.sv
`timescale 1ns/1ps
module tb_nic_pwr_stagger_arb;
   import nic_arb_pkg::*;

   localparam int NUM_SLOTS  = 4;
   localparam int GAP_MS     = 50;
   localparam int TIMEOUT_MS = 1200;
   localparam int IDX_W      = 2;

   logic                 iClk;
   logic                 iRst;
   logic                 iTick_1ms;
   logic [NUM_SLOTS-1:0] iPWR_REQ;
   logic [NUM_SLOTS-1:0] iPWR_DONE;
   logic [NUM_SLOTS-1:0] oPWR_EN;
   logic                 oGRANT_VLD;
   logic [IDX_W-1:0]     oGRANT_IDX;
   logic [NUM_SLOTS-1:0] oSLOT_FLT;
   logic [1:0]           oDBG_ARB_FSM_curr;

   int checks = 0;
   int errors = 0;

   nic_pwr_stagger_arb #(
      .NUM_SLOTS  (NUM_SLOTS),
      .GAP_MS     (GAP_MS),
      .TIMEOUT_MS (TIMEOUT_MS)
   ) dut (
      .iClk              (iClk),
      .iRst              (iRst),
      .iTick_1ms         (iTick_1ms),
      .iPWR_REQ          (iPWR_REQ),
      .iPWR_DONE         (iPWR_DONE),
      .oPWR_EN           (oPWR_EN),
      .oGRANT_VLD        (oGRANT_VLD),
      .oGRANT_IDX        (oGRANT_IDX),
      .oSLOT_FLT         (oSLOT_FLT),
      .oDBG_ARB_FSM_curr (oDBG_ARB_FSM_curr)
   );

   // Clock / reset: 2MHz clock
   initial iClk = 1'b0;
   always #250 iClk = ~iClk;

   // Global time limit
   initial begin
      #(60000 * 500);
      $display("FAIL watchdog: observed no finish, expected finish within 60000 cycles");
      $fatal(1, "watchdog expired");
   end

   // Driver tasks: advance to just after the next active edge
   task automatic step(input int n);
      repeat (n) @(posedge iClk);
      #1;
   endtask

   // Each tick: one edge with tick low, then one edge with tick high.
   // Returns right after the tick edge.
   task automatic tickCycles(input int n);
      for (int t = 0; t < n; t++) begin
         iTick_1ms = 1'b0;
         step(1);
         iTick_1ms = 1'b1;
         step(1);
      end
      iTick_1ms = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chkGrant(input string tag, input logic [3:0] en, input int idx);
      chk({tag, "_state"}, 32'(oDBG_ARB_FSM_curr), 32'(ST_WAIT));
      chk({tag, "_vld"},   32'(oGRANT_VLD), 32'd1);
      chk({tag, "_idx"},   32'(oGRANT_IDX), 32'(idx));
      chk({tag, "_en"},    32'(oPWR_EN), 32'(en));
   endtask

   // Full stagger gap: still in GAP after GAP_MS ticks, IDLE one edge later.
   task automatic finishGap(input string tag);
      tickCycles(GAP_MS);
      chk({tag, "_gap_hold"}, 32'(oDBG_ARB_FSM_curr), 32'(ST_GAP));
      step(1);
      chk({tag, "_gap_end"}, 32'(oDBG_ARB_FSM_curr), 32'(ST_IDLE));
   endtask

   initial begin
      iRst      = 1'b1;
      iTick_1ms = 1'b0;
      iPWR_REQ  = '0;
      iPWR_DONE = '0;
      step(2);
      chk("rst_state", 32'(oDBG_ARB_FSM_curr), 32'(ST_IDLE));
      chk("rst_en",    32'(oPWR_EN), 32'h0);
      chk("rst_vld",   32'(oGRANT_VLD), 32'd0);
      chk("rst_idx",   32'(oGRANT_IDX), 32'd0);
      chk("rst_flt",   32'(oSLOT_FLT), 32'h0);
      iRst = 1'b0;
      step(1);
      chk("idle_nopend", 32'(oDBG_ARB_FSM_curr), 32'(ST_IDLE));

      // 1: slots 0 and 2 request together; slot 0 first
      iPWR_REQ = 4'b0101;
      step(1);
      chkGrant("t1_g0", 4'b0001, 0);
      tickCycles(1060);
      chk("t1_wait_1060", 32'(oDBG_ARB_FSM_curr), 32'(ST_WAIT));
      iPWR_DONE = 4'b0001;
      step(1);
      chk("t1_gap", 32'(oDBG_ARB_FSM_curr), 32'(ST_GAP));
      chk("t1_gap_vld", 32'(oGRANT_VLD), 32'd0);
      chk("t1_gap_en", 32'(oPWR_EN), 32'h1);
      finishGap("t1a");
      step(1);
      chkGrant("t1_g2", 4'b0101, 2);
      iPWR_DONE = 4'b0101;
      step(1);
      chk("t1_both_en", 32'(oPWR_EN), 32'h5);
      finishGap("t1b");
      step(3);
      chk("t1_idle_stay", 32'(oDBG_ARB_FSM_curr), 32'(ST_IDLE));

      // Release everything
      iPWR_REQ  = '0;
      iPWR_DONE = '0;
      step(1);
      chk("rel_all_en", 32'(oPWR_EN), 32'h0);

      // 2: set ptr=1 by serving slot 1, then slots 0,1,3 -> order 3,0,1
      iPWR_REQ = 4'b0010;
      step(1);
      chkGrant("t2_g1pre", 4'b0010, 1);
      iPWR_DONE = 4'b0010;
      step(1);
      iPWR_REQ  = 4'b0000;
      iPWR_DONE = 4'b0000;
      step(1);
      chk("t2_gap_rel", 32'(oPWR_EN), 32'h0);
      iPWR_REQ = 4'b1011;
      finishGap("t2a");
      step(1);
      chkGrant("t2_g3", 4'b1000, 3);
      iPWR_DONE = 4'b1000;
      step(1);
      finishGap("t2b");
      step(1);
      chkGrant("t2_g0", 4'b1001, 0);
      iPWR_DONE = 4'b1001;
      step(1);
      finishGap("t2c");
      step(1);
      chkGrant("t2_g1", 4'b1011, 1);
      iPWR_DONE = 4'b1011;
      step(1);
      finishGap("t2d");

      // 5: slot 0 in WAIT, non-granted slot 3 drops its request
      iPWR_REQ = 4'b1010;
      step(1);
      chk("t5_rel0", 32'(oPWR_EN), 32'hA);
      iPWR_REQ  = 4'b1011;
      iPWR_DONE = 4'b1010;
      step(1);
      chkGrant("t5_g0", 4'b1011, 0);
      iPWR_REQ = 4'b0011;
      step(1);
      chkGrant("t5_drop3", 4'b0011, 0);

      // 4: granted slot 0 drops request with done in the same cycle
      iPWR_REQ  = 4'b0010;
      iPWR_DONE = 4'b0011;
      step(1);
      chk("t4_state", 32'(oDBG_ARB_FSM_curr), 32'(ST_GAP));
      chk("t4_en", 32'(oPWR_EN), 32'h2);
      chk("t4_vld", 32'(oGRANT_VLD), 32'd0);
      finishGap("t4");

      // 3: slot 1 never reports done
      iPWR_REQ  = 4'b0000;
      iPWR_DONE = 4'b0000;
      step(1);
      iPWR_REQ = 4'b0010;
      step(1);
      chkGrant("t3_g1", 4'b0010, 1);
`ifdef NIC_ARB_TIMEOUT_EN
      tickCycles(TIMEOUT_MS);
      chk("t3_pre_to_state", 32'(oDBG_ARB_FSM_curr), 32'(ST_WAIT));
      chk("t3_pre_to_flt", 32'(oSLOT_FLT), 32'h0);
      step(1);
      chk("t3_to_state", 32'(oDBG_ARB_FSM_curr), 32'(ST_GAP));
      chk("t3_to_flt", 32'(oSLOT_FLT), 32'h2);
      chk("t3_to_en", 32'(oPWR_EN), 32'h0);
      finishGap("t3");
      step(3);
      chk("t3_skip_state", 32'(oDBG_ARB_FSM_curr), 32'(ST_IDLE));
      chk("t3_skip_en", 32'(oPWR_EN), 32'h0);
      iPWR_REQ = 4'b0000;
      step(1);
      chk("t3_flt_clr", 32'(oSLOT_FLT), 32'h0);
      iPWR_REQ = 4'b0010;
      step(1);
      chkGrant("t3_regrant", 4'b0010, 1);
`else
      tickCycles(TIMEOUT_MS + 100);
      chk("t3_nto_state", 32'(oDBG_ARB_FSM_curr), 32'(ST_WAIT));
      chk("t3_nto_flt", 32'(oSLOT_FLT), 32'h0);
      chk("t3_nto_en", 32'(oPWR_EN), 32'h2);
      iPWR_DONE = 4'b0010;
      step(1);
      finishGap("t3");
      iPWR_REQ  = 4'b0000;
      iPWR_DONE = 4'b0000;
      step(1);
      iPWR_REQ = 4'b0010;
      step(1);
      chkGrant("t3_regrant", 4'b0010, 1);
`endif

      // 6: reset during WAIT; restart serves slot 0 first
      iPWR_REQ = 4'b0111;
      iRst     = 1'b1;
      step(1);
      chk("t6_rst_state", 32'(oDBG_ARB_FSM_curr), 32'(ST_IDLE));
      chk("t6_rst_en",    32'(oPWR_EN), 32'h0);
      chk("t6_rst_vld",   32'(oGRANT_VLD), 32'd0);
      chk("t6_rst_idx",   32'(oGRANT_IDX), 32'd0);
      chk("t6_rst_flt",   32'(oSLOT_FLT), 32'h0);
      iRst = 1'b0;
      step(1);
      chkGrant("t6_g0", 4'b0001, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_nic_pwr_stagger_arb
